// File: rtl/alu_seq_pipe.sv
// Registered, handshaked ALU: ADD/SUB/AND/OR/XOR/NOT/SHL in one cycle.
// MUL is multi-cycle shift-add when ALU_SEQ_MUL_EN is defined; otherwise it returns zero.
module alu_seq_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Carry,
  output logic             Neg,
  output logic             Ovf
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_NOT = 3'b101, OP_SHL = 3'b110, OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
    S_BUSY = 2'd1,
`endif
    S_DONE = 2'd2
  } state_e;

  state_e           r_state, w_state_next;
  op_e              w_op;
  logic             w_accept;
  logic             w_load_single;
  logic [WIDTH:0]   w_sum, w_diff, w_shl;
  logic [WIDTH-1:0] w_res;
  logic             w_carry, w_ovf;

  assign w_op     = op_e'(ALUOp);
  assign w_accept = in_valid & in_ready;
  assign w_sum    = {1'b0, A} + {1'b0, B};
  assign w_diff   = {1'b0, A} - {1'b0, B};
  // Bit WIDTH of the widened shift holds the last bit pushed out (0 for a zero shift).
  assign w_shl    = {1'b0, A} << B[SHW-1:0];

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] r_mcand, r_acc, w_acc_next;
  logic [WIDTH-1:0]   r_mplier;
  logic [SHW-1:0]     r_cnt;
  logic               w_mul_last;

  assign w_acc_next    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last    = (r_state == S_BUSY) && (r_cnt == SHW'(WIDTH - 1));
  assign w_load_single = w_accept && (w_op != OP_MUL);
`else
  assign w_load_single = w_accept;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: w_res = A & B;
      OP_OR:  w_res = A | B;
      OP_XOR: w_res = A ^ B;
      OP_NOT: w_res = ~A;
      OP_SHL: begin
        w_res   = w_shl[WIDTH-1:0];
        w_carry = w_shl[WIDTH];
      end
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
`ifdef ALU_SEQ_MUL_EN
        w_state_next = (w_op == OP_MUL) ? S_BUSY : S_DONE;
`else
        w_state_next = S_DONE;
`endif
      end
`ifdef ALU_SEQ_MUL_EN
      S_BUSY: if (w_mul_last) w_state_next = S_DONE;
`endif
      S_DONE: if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

`ifdef ALU_SEQ_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept && (w_op == OP_MUL)) begin
      r_mcand  <= {{WIDTH{1'b0}}, A};
      r_mplier <= B;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
`endif

  // Result and flags load only on completion, so they hold through backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Result <= '0;
      Zero   <= 1'b0;
      Carry  <= 1'b0;
      Neg    <= 1'b0;
      Ovf    <= 1'b0;
    end else if (w_load_single) begin
      Result <= w_res;
      Zero   <= (w_res == '0);
      Carry  <= w_carry;
      Neg    <= w_res[WIDTH-1];
      Ovf    <= w_ovf;
    end
`ifdef ALU_SEQ_MUL_EN
    else if (w_mul_last) begin
      Result <= w_acc_next[WIDTH-1:0];
      Zero   <= (w_acc_next[WIDTH-1:0] == '0);
      Carry  <= |w_acc_next[2*WIDTH-1:WIDTH];
      Neg    <= w_acc_next[WIDTH-1];
      Ovf    <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_alu_seq_pipe.sv
// Directed bench for alu_seq_pipe (WIDTH=8); expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq_pipe;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] A, B, Result;
  logic [2:0] ALUOp;
  logic       Zero, Carry, Neg, Ovf;

  int n_vec = 0;
  int n_err = 0;

`ifdef ALU_SEQ_MUL_EN
  localparam int MUL_LAT = 9;
  localparam logic [11:0] MUL_EXP = {8'h10, 4'b0100};
`else
  localparam int MUL_LAT = 1;
  localparam logic [11:0] MUL_EXP = {8'h00, 4'b1000};
`endif

  alu_seq_pipe #(.WIDTH(8), .SHW(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUOp(ALUOp), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Zero(Zero), .Carry(Carry), .Neg(Neg), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {Result, Z, C, N, V}
  function automatic logic [11:0] pk();
    return {Result, Zero, Carry, Neg, Ovf};
  endfunction

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input int exp_lat, input logic [11:0] exp_v);
    int lat;
    @(negedge clk);
    A = a; B = b; ALUOp = op; in_valid = 1'b1; out_ready = 1'b0;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, 32'(pk()), 32'(exp_v));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; ALUOp = '0;
    #12;
    check("rst_out", 32'(pk()), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;

    run_op("add_c",   8'hF0, 8'h20, 3'b000, 1, {8'h10, 4'b0100});
    run_op("add_v",   8'h7F, 8'h01, 3'b000, 1, {8'h80, 4'b0011});
    run_op("sub_b",   8'h05, 8'h07, 3'b001, 1, {8'hFE, 4'b0110});
    run_op("sub_z",   8'h33, 8'h33, 3'b001, 1, {8'h00, 4'b1000});
    run_op("sub_v",   8'h80, 8'h01, 3'b001, 1, {8'h7F, 4'b0001});
    run_op("and",     8'hF0, 8'h3C, 3'b010, 1, {8'h30, 4'b0000});
    run_op("or",      8'hF0, 8'h0F, 3'b011, 1, {8'hFF, 4'b0010});
    run_op("xor",     8'hAA, 8'hFF, 3'b100, 1, {8'h55, 4'b0000});
    run_op("not",     8'h00, 8'h5A, 3'b101, 1, {8'hFF, 4'b0010});
    run_op("shl2",    8'hC1, 8'h02, 3'b110, 1, {8'h04, 4'b0100});
    run_op("shl0",    8'hC1, 8'h08, 3'b110, 1, {8'hC1, 4'b0010});
    run_op("shl7",    8'h03, 8'h07, 3'b110, 1, {8'h80, 4'b0110});
    run_op("mul",     8'h10, 8'h11, 3'b111, MUL_LAT, MUL_EXP);

    // Reset in the middle of a MUL (or while holding DONE without the multiplier).
    @(negedge clk);
    A = 8'h10; B = 8'h11; ALUOp = 3'b111; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(pk()), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_quiet", 32'(out_valid), 32'd0);
    run_op("post_rst", 8'h12, 8'h34, 3'b000, 1, {8'h46, 4'b0000});

    // Backpressure with in_valid held high and different operands pending.
    @(negedge clk);
    A = 8'hF0; B = 8'h20; ALUOp = 3'b000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 A = 8'h01; B = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", 32'(pk()), 32'({8'h10, 4'b0100}));
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_valid", 32'(out_valid), 32'd0);
    check("bp_idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_res", 32'(pk()), 32'({8'h02, 4'b0000}));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
